// File: rtl/led_fade_pkg.sv
// Shared defaults and brightness helpers for the LED fade driver.
package led_fade_pkg;

  localparam int unsigned DEF_NUM_CH   = 14;
  localparam int unsigned DEF_PWM_BITS = 8;

  typedef logic [DEF_PWM_BITS-1:0] bright_t;

  function automatic int unsigned max_level(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness register with hold/release/decay priority and PWM drive.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS   = DEF_PWM_BITS,
  parameter int unsigned DECAY_STEP = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                level,
  input  logic                fade_en,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                nonzero
);

  localparam logic [PWM_BITS-1:0] MAX_B  = PWM_BITS'(max_level(PWM_BITS));
  localparam logic [PWM_BITS-1:0] STEP_B = PWM_BITS'(DECAY_STEP);

  if (DECAY_STEP < 1 || DECAY_STEP > max_level(PWM_BITS)) begin : g_bad_step
    $error("led_fade_channel: DECAY_STEP must lie in 1..2^PWM_BITS-1");
  end

  logic [PWM_BITS-1:0] b;

  // A held input always wins, so a re-trigger jumps straight to full brightness.
  always_ff @(posedge clk) begin
    if (reset) begin
      b   <= '0;
      led <= 1'b0;
    end else begin
      if (level)        b <= MAX_B;
      else if (!fade_en) b <= '0;
      else if (tick)    b <= (b > STEP_B) ? b - STEP_B : '0;
      led <= (b == MAX_B) | (b > pwm_cnt);
    end
  end

  assign nonzero = (b != '0);

endmodule

// File: rtl/led_fade_driver.sv
// PIO-to-LED driver: input register, decay prescaler, shared PWM counter and per-channel faders.
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned PWM_BITS   = DEF_PWM_BITS,
  parameter int unsigned DECAY_DIV  = 50000,
  parameter int unsigned DECAY_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] level_in,
  input  logic              fade_en,
  output logic [NUM_CH-1:0] led_out,
  output logic              active
);

  localparam int unsigned PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DECAY_DIV - 1);

  logic [NUM_CH-1:0]   level_q;
  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_CH-1:0]   nonzero;
  logic                tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      pre_cnt <= '0;
      pwm_cnt <= '0;
      active  <= 1'b0;
    end else begin
      level_q <= level_in;
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      active  <= |nonzero;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .level  (level_q[i]),
      .fade_en(fade_en),
      .tick   (tick),
      .pwm_cnt(pwm_cnt),
      .led    (led_out[i]),
      .nonzero(nonzero[i])
    );
  end

endmodule
